matmul_result_dumper: RTL



---
 rtl/matmul_result_dumper_if.sv | 37 +++
 rtl/matmul_result_dumper.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/matmul_result_dumper_if.sv
// Data-memory read port plus the valid/ready result stream, bundled so the
// dumper and its host-side consumer share one port.
interface matmul_result_dumper_if;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rd0;
    logic [7:0]  mem_rd1;
    logic [7:0]  mem_rd2;
    logic [7:0]  mem_rd3;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output mem_addr,
        input  mem_rd0,
        input  mem_rd1,
        input  mem_rd2,
        input  mem_rd3,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport slave (
        input  mem_addr,
        output mem_rd0,
        output mem_rd1,
        output mem_rd2,
        output mem_rd3,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );
endinterface

// File: rtl/matmul_result_dumper.sv
// Waits for the core's program-end edge, then streams a cycle/instruction header,
// every result-matrix word from data memory, and a closing checksum word.
module matmul_result_dumper #(
    parameter int unsigned M        = 3,
    parameter int unsigned N        = 4,
    parameter int unsigned N2       = 1,
    parameter int unsigned RES_BASE = M*N*4 + N*N2*4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          cpu_done,
    input  logic [15:0]                   cpu_clock_count,
    input  logic [15:0]                   cpu_instr_cnt,
    matmul_result_dumper_if.master        bus,
    output logic                          busy,
    output logic                          dump_done,
    output logic [31:0]                   checksum
);

    localparam int unsigned WORDS = M*N2;
    localparam int unsigned CNT_W = $clog2(WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);
    localparam logic [31:0] BASE_ADDR = 32'(RES_BASE);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        SEND,
        CSUM,
        FIN
    } state_t;

    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] wordCnt_q, wordCnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             dumpDone_q, dumpDone_d;
    logic [31:0]      csum_q, csum_d;

    logic             trigger;
    logic             accept;
    logic [31:0]      memWord;

    // armed_q only rises once cpu_done has been seen low after reset, so a level
    // that is already high when reset releases cannot masquerade as an edge.
    assign trigger = cpu_done && !done_q && armed_q;
    assign accept  = valid_q && bus.out_ready;
    assign memWord = {bus.mem_rd0, bus.mem_rd1, bus.mem_rd2, bus.mem_rd3};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
            wordCnt_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            dumpDone_q <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            armed_q    <= armed_d;
            wordCnt_q  <= wordCnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            dumpDone_q <= dumpDone_d;
            csum_q     <= csum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        done_d     = cpu_done;
        armed_d    = armed_q || !cpu_done;
        wordCnt_d  = wordCnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        busy_d     = busy_q;
        dumpDone_d = dumpDone_q;
        csum_d     = csum_q;

        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    data_d    = {cpu_clock_count, cpu_instr_cnt};
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    addr_d    = BASE_ADDR;
                    wordCnt_d = '0;
                    csum_d    = '0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = RD;
                end
            end
            // mem_addr has been stable since the previous accept, so the combinational read is settled here.
            RD: begin
                data_d  = memWord;
                csum_d  = csum_q + memWord;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (accept) begin
                    wordCnt_d = wordCnt_q + CNT_W'(1);
                    addr_d    = addr_q + 32'd4;
                    if (wordCnt_q == LAST_IDX) begin
                        data_d  = csum_q;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        state_d = CSUM;
                    end else begin
                        valid_d = 1'b0;
                        state_d = RD;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    busy_d     = 1'b0;
                    dumpDone_d = 1'b1;
                    state_d    = FIN;
                end
            end
            FIN: begin
                state_d = FIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign busy          = busy_q;
    assign dump_done     = dumpDone_q;
    assign checksum      = csum_q;

endmodule
